multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control FSM for the LEGv8 subset (LDUR, STUR, CBZ, ADD/SUB/AND/ORR). It sequences the shared single-memory datapath through FETCH, DECODE, EXEC, MEM, WB and BRANCH states, driving the same control lines as the single-cycle main decoder plus the multicycle extras IRWrite, PCWrite and IorD. It sits between the instruction register and the datapath, and stalls on a memory-ready handshake. It flags unsupported opcodes and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- Op  in  11  opcode field of the instruction register (IR[31:21]); sampled in DECODE.
- mem_ready  in  1  memory handshake; the current FETCH or MEM access completes on a posedge with mem_ready=1.
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
- ALUOp  out  2  ALU control class: 00 add, 01 pass-B/zero test, 10 R-type funct.
- IRWrite, PCWrite, IorD  out  1 each  IR load, PC+4 load, memory address select (0=PC, 1=ALU result).
- exc  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  32  retired-instruction counter.

## Operation
- Op classes:
  - LD = 111_1100_0010
  - ST = 111_1100_0000
  - CB = 101_1010_0xxx
  - R = 10001011000, 11001011000, 10001010000, 10101010000
  - every other value = BAD.
- The class is latched into an opclass register on the DECODE→next transition. Outputs in later states use the latched class, not the live Op.
- State transitions:
  - FETCH→DECODE when mem_ready=1; otherwise stay in FETCH.
  - DECODE→EXEC for LD, ST, R; →BRANCH for CB; →EXC for BAD.
  - EXEC→MEM for LD, ST; →WB for R.
  - MEM→WB for LD when mem_ready=1; MEM→FETCH for ST when mem_ready=1; otherwise stay in MEM.
  - WB, BRANCH and EXC →FETCH unconditionally.
- Outputs are Moore, except IRWrite and PCWrite. Any signal not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, IRWrite=PCWrite=mem_ready.
  - DECODE: Reg2Loc=1 if Op is ST or CB.
  - EXEC (LD/ST): ALUSrc=1, ALUOp=00; Reg2Loc=1 for ST.
  - EXEC (R): ALUSrc=0, ALUOp=10.
  - MEM (LD): MemRead=1, IorD=1, ALUSrc=1.
  - MEM (ST): MemWrite=1, IorD=1, ALUSrc=1, Reg2Loc=1.
  - WB (LD): RegWrite=1, MemtoReg=1.
  - WB (R): RegWrite=1, MemtoReg=0, ALUOp=10.
  - BRANCH: Branch=1, ALUOp=01, Reg2Loc=1. The datapath gates the branch PC load with the ALU zero flag.
  - EXC: exc=1.
- instret increments by 1 on each transition into FETCH from WB, BRANCH, or MEM(ST). It does not increment from EXC. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset: on a posedge with reset_n=0, state←FETCH, opclass←BAD, instret←0.
- While reset_n=0, all control outputs and exc are forced to 0 combinationally, so no memory access is issued during reset. Reset mid-instruction aborts it with no retire.
- Latency with mem_ready held at 1:
  - LD: 5 cycles
  - ST: 4 cycles
  - R: 4 cycles
  - CB: 3 cycles
  - BAD: 3 cycles (exc asserted in cycle 3).
- Each cycle with mem_ready=0 in FETCH or MEM adds exactly one cycle. Outputs stay stable during the stall.
- mem_ready is ignored in every state other than FETCH and MEM.
- Op changing outside DECODE has no effect.

## Structure
- Package ctrl_pkg holds:
  - state_t enum {FETCH, DECODE, EXEC, MEM, WB, BRANCH, EXC}
  - opclass_t enum {LD, ST, CB, R, BAD}
  - opcode constants for the values listed under Operation.
- Sub-module opclass_dec: purely combinational, Op[10:0] → opclass_t. multicycle_ctrl contains the state register, opclass register, output decode and instret counter.

## Test plan
- Reset, then LD (Op=7C2) with mem_ready=1:
  - state sequence FETCH, DECODE, EXEC, MEM, WB.
  - MEM cycle: MemRead=1, IorD=1.
  - WB cycle: RegWrite=1, MemtoReg=1.
  - instret=1 afterwards.
- ST (7C0) with mem_ready=0 for 3 cycles in MEM:
  - MemWrite=1 for 4 cycles, RegWrite never 1.
  - returns to FETCH; instret increments once.
- CBZ (Op=5A0–5A7, test all 8):
  - BRANCH reached in the 3rd cycle with Branch=1, ALUOp=01, Reg2Loc=1.
- R-type ADD (458) and ORR (550):
  - EXEC: ALUOp=10, ALUSrc=0.
  - WB: RegWrite=1, MemtoReg=0.
- Op=7F8 (BAD):
  - exc=1 for exactly one cycle, no RegWrite or MemWrite, instret unchanged.
- Checks of reset_n and instret:
  - reset_n=0 during MEM of a LD: all outputs are 0 immediately; after release, FETCH with instret=0.
  - preload instret=0xFFFF_FFFF via force, retire one instruction: instret=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the LEGv8 multicycle control FSM.
package ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, BRANCH, EXC} state_t;
  typedef enum logic [2:0] {LD, ST, CB, R, BAD} opclass_t;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  // CBZ only fixes Op[10:3]; the low three bits belong to the immediate.
  localparam logic [7:0]  OP_CBZ_HI = 8'hB4;

endpackage

// File: rtl/opclass_dec.sv
// Combinational opcode classifier: IR[31:21] -> opclass_t.
module opclass_dec
  import ctrl_pkg::*;
(
  input  logic [10:0] Op,
  output opclass_t    opclass_o
);

  always_comb begin
    opclass_o = BAD;
    if (Op == OP_LDUR)                 opclass_o = LD;
    else if (Op == OP_STUR)            opclass_o = ST;
    else if (Op[10:3] == OP_CBZ_HI)    opclass_o = CB;
    else if (Op == OP_ADD || Op == OP_SUB ||
             Op == OP_AND || Op == OP_ORR) opclass_o = R;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: state/opclass registers, output decode and
// retired-instruction counter, stalling FETCH/MEM on mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] Op,
  input  logic        mem_ready,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        IorD,
  output logic        exc,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  opclass_t    opclass_q, dec_class;
  logic [31:0] instret_q, instret_d;

  opclass_dec u_dec (.Op(Op), .opclass_o(dec_class));

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: case (dec_class)
                LD, ST, R: state_d = EXEC;
                CB:        state_d = BRANCH;
                default:   state_d = EXC;
              endcase
      EXEC:   state_d = (opclass_q == R) ? WB : MEM;
      MEM:    if (mem_ready) state_d = (opclass_q == ST) ? FETCH : WB;
      default: state_d = FETCH;
    endcase
    // Retire on every path back to FETCH except the exception path.
    if (state_q == WB || state_q == BRANCH ||
        (state_q == MEM && opclass_q == ST && mem_ready))
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      opclass_q <= BAD;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      if (state_q == DECODE) opclass_q <= dec_class;
    end
  end

  // Outputs are held low while reset_n is low so no memory cycle leaks out.
  always_comb begin
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    exc      = 1'b0;
    if (reset_n) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: Reg2Loc = (dec_class == ST) || (dec_class == CB);
        EXEC: begin
          if (opclass_q == R) begin
            ALUOp = 2'b10;
          end else begin
            ALUSrc  = 1'b1;
            Reg2Loc = (opclass_q == ST);
          end
        end
        MEM: begin
          IorD   = 1'b1;
          ALUSrc = 1'b1;
          if (opclass_q == ST) begin
            MemWrite = 1'b1;
            Reg2Loc  = 1'b1;
          end else begin
            MemRead = 1'b1;
          end
        end
        WB: begin
          RegWrite = 1'b1;
          if (opclass_q == R) ALUOp = 2'b10;
          else                MemtoReg = 1'b1;
        end
        BRANCH: begin
          Branch  = 1'b1;
          ALUOp   = 2'b01;
          Reg2Loc = 1'b1;
        end
        EXC:     exc = 1'b1;
        default: ;
      endcase
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues hand-computed
// per-cycle expectations, a monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] Op;
  logic        mem_ready;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic        IRWrite, PCWrite, IorD, exc;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .mem_ready(mem_ready),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUOp(ALUOp), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .IorD(IorD), .exc(exc), .instret(instret)
  );

  always #5 clk = ~clk;

  // Control vector layout: R2L ASRC M2R RW MR MW BR ALUOp[1:0] IRW PCW IORD EXC
  localparam logic [12:0] R2L   = 13'h1000;
  localparam logic [12:0] ASRC  = 13'h0800;
  localparam logic [12:0] M2R   = 13'h0400;
  localparam logic [12:0] RW    = 13'h0200;
  localparam logic [12:0] MR    = 13'h0100;
  localparam logic [12:0] MW    = 13'h0080;
  localparam logic [12:0] BR    = 13'h0040;
  localparam logic [12:0] AOP10 = 13'h0020;
  localparam logic [12:0] AOP01 = 13'h0010;
  localparam logic [12:0] IRW   = 13'h0008;
  localparam logic [12:0] PCW   = 13'h0004;
  localparam logic [12:0] IORD  = 13'h0002;
  localparam logic [12:0] EXCB  = 13'h0001;
  localparam logic [12:0] FET   = MR | IRW | PCW;

  typedef struct {
    logic [12:0] ctrl;
    state_t      st;
    logic [31:0] inst;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [12:0] act;
      e   = exp_q.pop_front();
      act = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
             ALUOp, IRWrite, PCWrite, IorD, exc};
      total++;
      if (act !== e.ctrl) begin
        bad++;
        $display("FAIL %s ctrl: got %013b want %013b", e.nm, act, e.ctrl);
      end
      total++;
      if (dut.state_q !== e.st) begin
        bad++;
        $display("FAIL %s state: got %0d want %0d", e.nm, dut.state_q, e.st);
      end
      total++;
      if (instret !== e.inst) begin
        bad++;
        $display("FAIL %s instret: got %h want %h", e.nm, instret, e.inst);
      end
    end
  end

  // Drive one cycle of inputs and queue what that cycle must look like.
  task automatic step(input logic [10:0] op, input logic mr, input logic rn,
                      input logic [12:0] c, input state_t s,
                      input logic [31:0] n, input string nm);
    exp_t e;
    Op = op; mem_ready = mr; reset_n = rn;
    e.ctrl = c; e.st = s; e.inst = n; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  logic [31:0] ic;

  initial begin
    reset_n = 1'b0; Op = '0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step(11'h000, 1, 0, 13'h0, FETCH, 0, "reset");

    // LD with no stalls
    step(OP_LDUR, 1, 1, FET,             FETCH,  0, "ld_fetch");
    step(OP_LDUR, 1, 1, 13'h0,           DECODE, 0, "ld_decode");
    step(OP_LDUR, 1, 1, ASRC,            EXEC,   0, "ld_exec");
    step(OP_LDUR, 1, 1, MR | IORD | ASRC, MEM,   0, "ld_mem");
    step(OP_LDUR, 1, 1, RW | M2R,        WB,     0, "ld_wb");

    // ST, three MEM stall cycles; Op garbage outside DECODE must not matter
    step(OP_STUR, 1, 1, FET,               FETCH,  1, "st_fetch");
    step(OP_STUR, 1, 1, R2L,               DECODE, 1, "st_decode");
    step(11'h7F8, 1, 1, ASRC | R2L,        EXEC,   1, "st_exec");
    for (int i = 0; i < 3; i++)
      step(11'h458, 0, 1, MW | IORD | ASRC | R2L, MEM, 1, "st_mem_stall");
    step(11'h458, 1, 1, MW | IORD | ASRC | R2L, MEM, 1, "st_mem_done");

    // All eight CBZ encodings
    ic = 2;
    for (int k = 0; k < 8; k++) begin
      logic [10:0] cop;
      cop = {OP_CBZ_HI, 3'(k)};
      step(cop, 1, 1, FET,               FETCH,  ic, "cb_fetch");
      step(cop, 1, 1, R2L,               DECODE, ic, "cb_decode");
      step(cop, 0, 1, BR | AOP01 | R2L,  BRANCH, ic, "cb_branch");
      ic++;
    end

    // R-type ADD then ORR
    step(OP_ADD, 1, 1, FET,        FETCH,  10, "add_fetch");
    step(OP_ADD, 1, 1, 13'h0,      DECODE, 10, "add_decode");
    step(OP_ADD, 1, 1, AOP10,      EXEC,   10, "add_exec");
    step(OP_ADD, 1, 1, RW | AOP10, WB,     10, "add_wb");
    step(OP_ORR, 1, 1, FET,        FETCH,  11, "orr_fetch");
    step(OP_ORR, 1, 1, 13'h0,      DECODE, 11, "orr_decode");
    step(OP_ORR, 1, 1, AOP10,      EXEC,   11, "orr_exec");
    step(OP_ORR, 1, 1, RW | AOP10, WB,     11, "orr_wb");

    // BAD opcode, with one FETCH stall first
    step(11'h7F8, 0, 1, MR,    FETCH,  12, "bad_fetch_stall");
    step(11'h7F8, 1, 1, FET,   FETCH,  12, "bad_fetch");
    step(11'h7F8, 1, 1, 13'h0, DECODE, 12, "bad_decode");
    step(11'h7F8, 1, 1, EXCB,  EXC,    12, "bad_exc");

    // LD aborted by reset during MEM
    step(OP_LDUR, 1, 1, FET,              FETCH,  12, "rld_fetch");
    step(OP_LDUR, 1, 1, 13'h0,            DECODE, 12, "rld_decode");
    step(OP_LDUR, 1, 1, ASRC,             EXEC,   12, "rld_exec");
    step(OP_LDUR, 1, 0, 13'h0,            MEM,    12, "rld_reset");
    step(OP_LDUR, 1, 1, FET,              FETCH,  0,  "rld_after");

    // instret wrap
    step(OP_ADD, 1, 1, 13'h0, DECODE, 0, "wrap_decode0");
    step(OP_ADD, 1, 1, AOP10, EXEC,   0, "wrap_exec0");
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    step(OP_ADD, 1, 1, RW | AOP10, WB,    32'hFFFF_FFFF, "wrap_wb");
    step(OP_ADD, 1, 1, FET,        FETCH, 32'h0,         "wrap_fetch");

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
